// File: rtl/pam_frame_arbiter.sv
// -----------------------------------------------------------------------------
// pam_frame_arbiter
//
// Round-robin arbiter that shares the PAM modulator's byte-wide FIFO-style
// interface between NUM_SRC first-word-fall-through byte FIFOs. A grant lasts
// for exactly one frame of FRAME_BYTES bytes, so a symbol assembled downstream
// never mixes bytes from different sources. If the granted source stays empty
// for STALL_MAX consecutive cycles mid-frame, the rest of the frame is padded
// with IDLE_BYTE and an underrun is flagged.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   enable          allows new grants (an in-progress frame always completes)
//   src_mask        per-source eligibility, looked at only while arbitrating
//   src_data        source i byte at [8i+7:8i]
//   src_empty       per-source FIFO empty
//   src_read        per-source pop strobe
//   mod_sample      byte presented to the modulator
//   mod_empty       modulator-side empty
//   mod_read        modulator pop strobe
//   grant_id        currently / last granted source
//   frame_done      pulse in the cycle the final byte of a frame is accepted
//   underrun        pulse in the cycle the frame switches to padding
//   underrun_count  saturating count of padded frames
// -----------------------------------------------------------------------------
module pam_frame_arbiter #(
    parameter int         NUM_SRC     = 4,
    parameter int         FRAME_BYTES = 3,
    parameter int         STALL_MAX   = 16,
    parameter logic [7:0] IDLE_BYTE   = 8'h00
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic [NUM_SRC-1:0]         src_mask,
    input  logic [NUM_SRC*8-1:0]       src_data,
    input  logic [NUM_SRC-1:0]         src_empty,
    output logic [NUM_SRC-1:0]         src_read,
    output logic [7:0]                 mod_sample,
    output logic                       mod_empty,
    input  logic                       mod_read,
    output logic [$clog2(NUM_SRC)-1:0] grant_id,
    output logic                       frame_done,
    output logic                       underrun,
    output logic [15:0]                underrun_count
);
    localparam int ID_W = $clog2(NUM_SRC);
    localparam int BC_W = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
    localparam int SC_W = $clog2(STALL_MAX + 1);
    localparam logic [BC_W-1:0] LAST_BYTE  = BC_W'(FRAME_BYTES - 1);
    localparam logic [SC_W-1:0] STALL_LAST = SC_W'(STALL_MAX - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        PAD  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [BC_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [SC_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [ID_W-1:0]   grant_d;
    logic [ID_W-1:0]   last_grant_q, last_grant_d;
    logic              count_inc;

    logic [NUM_SRC-1:0] eligible;
    logic [ID_W-1:0]    cand;
    logic [ID_W-1:0]    winner;
    logic               win_found;
    logic [7:0]         sel_data;
    logic               sel_empty;
    logic               accept;

    assign eligible = src_mask & ~src_empty;

    // Round-robin search: first eligible source strictly after last_grant,
    // wrapping at NUM_SRC. The previous winner is therefore checked last.
    always_comb begin
        cand      = '0;
        winner    = '0;
        win_found = 1'b0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            cand = ID_W'((int'(last_grant_q) + k) % NUM_SRC);
            if (!win_found && eligible[cand]) begin
                winner    = cand;
                win_found = 1'b1;
            end
        end
    end

    // Pass-through mux for the granted source.
    always_comb begin
        sel_data  = '0;
        sel_empty = 1'b1;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_id == ID_W'(i)) begin
                sel_data  = src_data[i*8 +: 8];
                sel_empty = src_empty[i];
            end
        end
    end

    assign accept = mod_read & ~sel_empty;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can
        // leave one unassigned and infer a latch.
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        stall_cnt_d  = stall_cnt_q;
        grant_d      = grant_id;
        last_grant_d = last_grant_q;
        count_inc    = 1'b0;
        src_read     = '0;
        mod_sample   = '0;
        mod_empty    = 1'b1;
        frame_done   = 1'b0;
        underrun     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (enable && win_found) begin
                    grant_d     = winner;
                    byte_cnt_d  = '0;
                    stall_cnt_d = '0;
                    state_d     = PASS;
                end
            end

            PASS: begin
                mod_sample = sel_data;
                mod_empty  = sel_empty;
                for (int i = 0; i < NUM_SRC; i++) begin
                    if (grant_id == ID_W'(i)) src_read[i] = accept;
                end
                if (accept) begin
                    byte_cnt_d  = byte_cnt_q + 1'b1;
                    stall_cnt_d = '0;
                    if (byte_cnt_q == LAST_BYTE) begin
                        frame_done   = 1'b1;
                        last_grant_d = grant_id;
                        state_d      = IDLE;
                    end
                end else if (sel_empty) begin
                    if (stall_cnt_q == STALL_LAST) begin
                        underrun  = 1'b1;
                        count_inc = 1'b1;
                        state_d   = PAD;
                    end else begin
                        stall_cnt_d = stall_cnt_q + 1'b1;
                    end
                end else begin
                    // Source has data but the modulator is not reading: the
                    // empty run is broken, so the stall timer starts over.
                    stall_cnt_d = '0;
                end
            end

            PAD: begin
                mod_sample = IDLE_BYTE;
                mod_empty  = 1'b0;
                if (mod_read) begin
                    byte_cnt_d = byte_cnt_q + 1'b1;
                    if (byte_cnt_q == LAST_BYTE) begin
                        frame_done   = 1'b1;
                        last_grant_d = grant_id;
                        state_d      = IDLE;
                    end
                end
            end

            default: state_d = IDLE;
        endcase

        // While reset is held the outputs already show their reset values, so
        // an abandoned frame can neither pop a source nor pulse a flag.
        if (rst) begin
            src_read   = '0;
            mod_sample = '0;
            mod_empty  = 1'b1;
            frame_done = 1'b0;
            underrun   = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            byte_cnt_q     <= '0;
            stall_cnt_q    <= '0;
            grant_id       <= '0;
            last_grant_q   <= ID_W'(NUM_SRC - 1);
            underrun_count <= '0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
            grant_id     <= grant_d;
            last_grant_q <= last_grant_d;
            if (count_inc && underrun_count != 16'hFFFF) begin
                underrun_count <= underrun_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_pam_frame_arbiter.sv
// -----------------------------------------------------------------------------
// tb_pam_frame_arbiter
//
// Self-checking bench for pam_frame_arbiter. The bench owns the source FIFOs
// (queues) and a frame-level reference model that predicts, per cycle, which
// bytes the modulator receives, which source is popped, and when frames end or
// underrun. Predictions go into scoreboard queues stamped with the cycle; an
// independent monitor pops and compares whenever the DUT shows an event.
// -----------------------------------------------------------------------------
module tb_pam_frame_arbiter;
    localparam int         NUM_SRC     = 4;
    localparam int         FRAME_BYTES = 3;
    localparam int         STALL_MAX   = 16;
    localparam logic [7:0] IDLE_BYTE   = 8'h00;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 enable;
    logic [NUM_SRC-1:0]   src_mask;
    logic [NUM_SRC*8-1:0] src_data;
    logic [NUM_SRC-1:0]   src_empty;
    logic [NUM_SRC-1:0]   src_read;
    logic [7:0]           mod_sample;
    logic                 mod_empty;
    logic                 mod_read;
    logic [1:0]           grant_id;
    logic                 frame_done;
    logic                 underrun;
    logic [15:0]          underrun_count;

    pam_frame_arbiter #(
        .NUM_SRC    (NUM_SRC),
        .FRAME_BYTES(FRAME_BYTES),
        .STALL_MAX  (STALL_MAX),
        .IDLE_BYTE  (IDLE_BYTE)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .src_mask      (src_mask),
        .src_data      (src_data),
        .src_empty     (src_empty),
        .src_read      (src_read),
        .mod_sample    (mod_sample),
        .mod_empty     (mod_empty),
        .mod_read      (mod_read),
        .grant_id      (grant_id),
        .frame_done    (frame_done),
        .underrun      (underrun),
        .underrun_count(underrun_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int src;
        int data;
    } ev_t;

    ev_t exp_bytes[$];
    ev_t exp_pops[$];
    ev_t exp_frames[$];
    ev_t exp_unders[$];

    logic [7:0] src_q[NUM_SRC][$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model state: one frame in flight at most.
    bit m_busy;
    bit m_pad;
    int m_g;
    int m_n;
    int m_stall;
    int m_last;
    int m_ucount;

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic note_fail(string name, int a, int b);
        checks++;
        failures++;
        $display("FAIL %s: cycle %0d value %0d (now cycle %0d)", name, a, b, cyc);
    endtask

    // Frame-level prediction for the current cycle from the current inputs.
    task automatic model_step();
        bit found;
        int s;
        if (rst) begin
            m_busy   = 0;
            m_pad    = 0;
            m_last   = NUM_SRC - 1;
            m_ucount = 0;
        end else if (!m_busy) begin
            found = 0;
            if (enable) begin
                for (int k = 1; k <= NUM_SRC; k++) begin
                    s = (m_last + k) % NUM_SRC;
                    if (!found && src_mask[s] && src_q[s].size() != 0) begin
                        found = 1;
                        m_g   = s;
                    end
                end
            end
            if (found) begin
                m_busy  = 1;
                m_pad   = 0;
                m_n     = 0;
                m_stall = 0;
            end
        end else if (!m_pad) begin
            if (src_q[m_g].size() != 0) begin
                m_stall = 0;
                if (mod_read) begin
                    exp_bytes.push_back('{cyc, m_g, int'(src_q[m_g][0])});
                    exp_pops.push_back('{cyc, m_g, 0});
                    m_n++;
                    if (m_n == FRAME_BYTES) begin
                        exp_frames.push_back('{cyc, m_g, 0});
                        m_last = m_g;
                        m_busy = 0;
                    end
                end
            end else begin
                m_stall++;
                if (m_stall == STALL_MAX) begin
                    exp_unders.push_back('{cyc, m_g, 0});
                    m_pad = 1;
                    if (m_ucount < 65535) m_ucount++;
                end
            end
        end else if (mod_read) begin
            exp_bytes.push_back('{cyc, m_g, int'(IDLE_BYTE)});
            m_n++;
            if (m_n == FRAME_BYTES) begin
                exp_frames.push_back('{cyc, m_g, 0});
                m_last = m_g;
                m_busy = 0;
            end
        end
    endtask

    // One clock cycle: present FIFO fronts, predict, then pop what the DUT read.
    task automatic step();
        logic [NUM_SRC-1:0] pops;
        for (int i = 0; i < NUM_SRC; i++) begin
            src_empty[i] = (src_q[i].size() == 0);
            src_data[i*8 +: 8] = (src_q[i].size() != 0) ? src_q[i][0] : 8'($urandom);
        end
        model_step();
        @(negedge clk);
        pops = src_read;
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (pops[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
        end
        cyc++;
    endtask

    task automatic clear_fifos();
        for (int i = 0; i < NUM_SRC; i++) src_q[i].delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_fifos();
        step();
        step();
        rst = 1'b0;
    endtask

    // Monitor: compares DUT events against the scoreboard queues.
    always @(negedge clk) begin : monitor
        ev_t e;
        while (exp_bytes.size() != 0 && exp_bytes[0].cyc < cyc) begin
            e = exp_bytes.pop_front();
            note_fail("byte_missing", e.cyc, e.data);
        end
        while (exp_pops.size() != 0 && exp_pops[0].cyc < cyc) begin
            e = exp_pops.pop_front();
            note_fail("pop_missing", e.cyc, e.src);
        end
        while (exp_frames.size() != 0 && exp_frames[0].cyc < cyc) begin
            e = exp_frames.pop_front();
            note_fail("frame_done_missing", e.cyc, e.src);
        end
        while (exp_unders.size() != 0 && exp_unders[0].cyc < cyc) begin
            e = exp_unders.pop_front();
            note_fail("underrun_missing", e.cyc, e.src);
        end

        if (mod_read === 1'b1 && mod_empty === 1'b0) begin
            if (exp_bytes.size() == 0) note_fail("byte_unexpected", cyc, int'(mod_sample));
            else begin
                e = exp_bytes.pop_front();
                check("byte_cycle", cyc, e.cyc);
                check("byte_data", int'(mod_sample), e.data);
                check("byte_grant", int'(grant_id), e.src);
            end
        end
        if (src_read !== '0) begin
            if (exp_pops.size() == 0) note_fail("pop_unexpected", cyc, int'(src_read));
            else begin
                e = exp_pops.pop_front();
                check("pop_cycle", cyc, e.cyc);
                check("pop_onehot", int'(src_read), 1 << e.src);
            end
        end
        if (frame_done !== 1'b0) begin
            if (exp_frames.size() == 0) note_fail("frame_done_unexpected", cyc, int'(grant_id));
            else begin
                e = exp_frames.pop_front();
                check("frame_done_cycle", cyc, e.cyc);
                check("frame_done_grant", int'(grant_id), e.src);
            end
        end
        if (underrun !== 1'b0) begin
            if (exp_unders.size() == 0) note_fail("underrun_unexpected", cyc, int'(grant_id));
            else begin
                e = exp_unders.pop_front();
                check("underrun_cycle", cyc, e.cyc);
                check("underrun_grant", int'(grant_id), e.src);
            end
        end
    end

    initial begin
        rst       = 1'b1;
        enable    = 1'b0;
        src_mask  = '0;
        mod_read  = 1'b0;
        src_data  = '0;
        src_empty = '1;
        m_busy    = 0;
        m_pad     = 0;
        m_g       = 0;
        m_n       = 0;
        m_stall   = 0;
        m_last    = NUM_SRC - 1;
        m_ucount  = 0;

        @(posedge clk);
        #1;
        repeat (3) step();

        // Reset state with reset released and nothing to grant.
        rst = 1'b0;
        #1;
        check("rst_mod_empty", int'(mod_empty), 1);
        check("rst_mod_sample", int'(mod_sample), 0);
        check("rst_src_read", int'(src_read), 0);
        check("rst_grant_id", int'(grant_id), 0);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_underrun", int'(underrun), 0);
        check("rst_underrun_count", int'(underrun_count), 0);

        // Single source, continuous reads: two frames with one gap cycle.
        for (int j = 1; j <= 6; j++) src_q[0].push_back(8'hA0 + 8'(j));
        enable   = 1'b1;
        src_mask = 4'hF;
        mod_read = 1'b1;
        repeat (12) step();
        check("t1_src0_drained", src_q[0].size(), 0);

        // All four sources with one frame each: grants 0,1,2,3, then 0 again.
        do_reset();
        for (int i = 0; i < NUM_SRC; i++)
            for (int j = 0; j < 3; j++) src_q[i].push_back(8'((i + 1) * 16 + j));
        repeat (16) step();
        for (int i = 0; i < NUM_SRC; i++)
            for (int j = 0; j < 3; j++) src_q[i].push_back(8'((i + 5) * 16 + j));
        repeat (8) step();

        // Mask 1010: only sources 1 and 3 may be granted or popped.
        do_reset();
        src_mask = 4'b1010;
        for (int i = 0; i < NUM_SRC; i++)
            for (int j = 0; j < 9; j++) src_q[i].push_back(8'($urandom));
        repeat (16) step();
        check("t3_src0_untouched", src_q[0].size(), 9);
        check("t3_src2_untouched", src_q[2].size(), 9);

        // Underrun: src2 supplies one byte, then stays empty for 20 cycles.
        do_reset();
        src_mask = 4'hF;
        src_q[2].push_back(8'h5A);
        repeat (22) step();
        src_q[2].push_back(8'h6B);
        src_q[2].push_back(8'h7C);
        repeat (8) step();
        check("t4_underrun_count", int'(underrun_count), 1);

        // Reset one cycle after the second byte of a frame is accepted.
        do_reset();
        for (int j = 0; j < 6; j++) src_q[0].push_back(8'(8'hC0 + j));
        for (int j = 0; j < 3; j++) src_q[1].push_back(8'(8'hD0 + j));
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("t5_mod_empty", int'(mod_empty), 1);
        check("t5_src_read", int'(src_read), 0);
        check("t5_grant_id", int'(grant_id), 0);
        check("t5_frame_done", int'(frame_done), 0);
        repeat (40) step();

        // Enable dropped mid-frame: frame completes, no new grant until re-enabled.
        do_reset();
        for (int j = 0; j < 6; j++) src_q[0].push_back(8'(8'h30 + j));
        enable = 1'b1;
        repeat (2) step();
        enable = 1'b0;
        repeat (10) step();
        check("t6_one_frame_only", src_q[0].size(), 3);
        enable = 1'b1;
        repeat (6) step();
        check("t6_second_frame", src_q[0].size(), 0);

        // Randomized traffic against the reference model.
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            rst      = ($urandom_range(0, 399) == 0);
            enable   = ($urandom_range(0, 9) != 0);
            src_mask = 4'($urandom) | 4'($urandom);
            mod_read = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < NUM_SRC; i++)
                if ($urandom_range(0, 9) == 0 && src_q[i].size() < 8)
                    src_q[i].push_back(8'($urandom));
            step();
        end
        check("rand_underrun_count", int'(underrun_count), m_ucount);

        // Quiesce under reset, then confirm every prediction was matched.
        rst = 1'b1;
        step();
        @(negedge clk);
        #1;
        check("leftover_bytes", exp_bytes.size(), 0);
        check("leftover_pops", exp_pops.size(), 0);
        check("leftover_frames", exp_frames.size(), 0);
        check("leftover_underruns", exp_unders.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pam_frame_arbiter.md
Name: pam_frame_arbiter

Overview:
- Round-robin arbiter that shares the PAM modulator's byte-wide FIFO interface (sample/empty/read) between NUM_SRC byte FIFOs.
- Each grant covers exactly one frame of FRAME_BYTES bytes, so the 24-bit symbol assembled downstream never mixes sources.
- If the granted source runs dry mid-frame, the block pads the frame with IDLE_BYTE after a timeout and flags an underrun.
- Sits between the per-channel sample FIFOs and the modulator.

Parameters:
- NUM_SRC, 4, number of requesting FIFOs (2..8).
- FRAME_BYTES, 3, bytes per modulator frame.
- STALL_MAX, 16, consecutive cycles the granted source may be empty mid-frame before padding starts (>=1).
- IDLE_BYTE, 8'h00, byte used to pad an underrun frame.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  allows new grants; an in-progress frame always completes.
- src_mask  in  NUM_SRC  per-source eligibility; sampled only at arbitration.
- src_data  in  NUM_SRC*8  source i byte at [8i+7:8i] (FIFO first-word-fall-through).
- src_empty  in  NUM_SRC  per-source FIFO empty.
- src_read  out  NUM_SRC  per-source pop strobe.
- mod_sample  out  8  byte presented to the modulator.
- mod_empty  out  1  modulator-side empty.
- mod_read  in  1  modulator pop strobe.
- grant_id  out  clog2(NUM_SRC)  currently/last granted source.
- frame_done  out  1  one-cycle pulse when the final byte of a frame is accepted.
- underrun  out  1  one-cycle pulse on entering PAD.
- underrun_count  out  16  saturating count of padded frames.

Behaviour:
- Reset values:
  - src_read=0, mod_empty=1, mod_sample=0, grant_id=0.
  - frame_done=0, underrun=0, underrun_count=0.
  - State IDLE; last_grant=NUM_SRC-1, so source 0 wins first.
- Definitions:
  - Eligible set E = src_mask & ~src_empty.
  - Accepted byte = mod_read & ~mod_empty in the same cycle. mod_read while mod_empty=1 is ignored.
- IDLE:
  - Outputs: mod_empty=1, mod_sample=0, src_read=0.
  - If enable=1 and E!=0: winner = first set bit of E searching upward from last_grant+1, wrapping at NUM_SRC.
  - Register the winner into grant_id, clear byte_cnt and stall_cnt, go to PASS.
  - Grant latency: 1 cycle from a source becoming eligible in IDLE to mod_empty reflecting it.
- PASS (combinational pass-through of the granted source g):
  - mod_sample = src_data[g]; mod_empty = src_empty[g].
  - src_read[g] = mod_read & ~src_empty[g]; all other src_read bits = 0.
  - Each accepted byte increments byte_cnt and clears stall_cnt.
  - Accepted byte with byte_cnt==FRAME_BYTES-1:
    - pulse frame_done, set last_grant=g, go to IDLE.
    - Gives at least one mod_empty=1 cycle between frames.
  - If src_empty[g]=1: stall_cnt increments.
  - When stall_cnt reaches STALL_MAX-1 with src_empty[g] still 1:
    - next state PAD; pulse underrun.
    - underrun_count += 1, saturating at 16'hFFFF.
  - Changes to src_mask[g] or enable mid-frame have no effect.
- PAD:
  - Outputs: mod_sample=IDLE_BYTE, mod_empty=0, src_read=0 (nothing is popped from the source).
  - Accepted bytes increment byte_cnt.
  - On the final byte: pulse frame_done, set last_grant=g, go to IDLE.
  - Remaining source bytes stay in the FIFO and are sent as the start of that source's next frame.
- Widths:
  - byte_cnt is clog2(FRAME_BYTES) bits; stall_cnt is clog2(STALL_MAX+1) bits.
  - No wrap occurs inside a frame.
- Reset mid-frame:
  - Immediate return to reset values next cycle; the partial frame is abandoned.
  - No frame_done and no underrun pulse are generated.
- Single eligible source: it is re-granted each frame, with one IDLE cycle between frames.
- Invalid states decode to IDLE.

Test Plan:
- Only src0 non-empty, mask=4'hF, modulator reads continuously; bytes A1,A2,A3,A4,A5,A6 -> two frames on mod_sample, frame_done twice, grant_id=0, one mod_empty=1 cycle between frames.
- All four sources hold 3 bytes each, mask=4'hF -> grant order 0,1,2,3; next refill grants 0; each frame's 3 bytes come from a single source.
- mask=4'b1010 with all sources non-empty -> grants alternate 1,3,1,3; src0 and src2 never see src_read.
- src2 granted, supplies 1 byte then goes empty for 20 cycles, STALL_MAX=16 -> underrun pulses once at stall cycle 16; remaining 2 bytes = 8'h00; underrun_count=1; frame_done on the 3rd byte.
- rst asserted one cycle after the 2nd byte of a frame is accepted -> next cycle mod_empty=1, src_read=0, grant_id=0, no frame_done; after release, source 0 is granted first.
- enable dropped mid-frame -> current frame completes with frame_done; no new grant while enable=0 even with E!=0.
